// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the freq_meter block.
//   state_e  : measurement FSM states (IDLE, GATE, REPORT)
//   *_DEF    : default values for the top-level parameters
//   PERIOD_W : width of the optional period result (FREQ_METER_PERIOD_EN)
package freq_meter_pkg;

    localparam int unsigned GATE_CYCLES_DEF = 50_000_000;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned PERIOD_W        = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        REPORT = 2'd2
    } state_e;

endpackage : freq_meter_pkg

// File: rtl/freq_meter_edge_sync.sv
// edge_sync: SYNC_STAGES-deep synchronizer followed by a one-flop rising-edge
// detector for an asynchronous input.
//   clkin : system clock
//   rst   : synchronous active-low reset
//   d     : asynchronous input
//   rise  : one-cycle pulse on a synchronized 0->1 of d
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift chain plus one history flop for the edge compare.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clkin) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Decoded from flops only; the consumer samples it on the next edge.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : edge_sync

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over repeated GATE_CYCLES windows
// and reports each count through a valid/ack handshake.
//   clkin, rst      : clock, synchronous active-low reset
//   en              : run continuous windows while high
//   sig_in          : asynchronous signal under measurement
//   freq_out        : edge count of the last completed window
//   freq_valid      : unacknowledged result present; freq_ack accepts it
//   ovf             : count saturated in the reported window
//   overrun         : sticky, a result replaced an unacknowledged one
//   busy            : window in progress
//   period_out      : cycles between the last two edges of the reported
//                     window (only when FREQ_METER_PERIOD_EN is defined)
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    input  logic             freq_ack,
    output logic             ovf,
    output logic             overrun,
    output logic             busy
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [PERIOD_W-1:0] period_out
`endif
);

    localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic rise;

    state_e            state_q, state_d;
    logic [GATE_W-1:0] gate_q,  gate_d;
    logic [CNT_W-1:0]  edge_q,  edge_d;
    logic              sat_q,   sat_d;
    logic [CNT_W-1:0]  freq_q,  freq_d;
    logic              valid_q, valid_d;
    logic              ovf_q,   ovf_d;
    logic              overrun_q, overrun_d;
    logic              busy_q,  busy_d;
`ifdef FREQ_METER_PERIOD_EN
    logic [PERIOD_W-1:0] since_q,   since_d;
    logic [PERIOD_W-1:0] win_per_q, win_per_d;
    logic [PERIOD_W-1:0] per_q,     per_d;
`endif

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clkin(clkin),
        .rst  (rst),
        .d    (sig_in),
        .rise (rise)
    );

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        edge_d    = edge_q;
        sat_d     = sat_q;
        freq_d    = freq_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        overrun_d = overrun_q;
        busy_d    = busy_q;
`ifdef FREQ_METER_PERIOD_EN
        since_d   = since_q;
        win_per_d = win_per_q;
        per_d     = per_q;
        // Cycles since the most recent edge, saturating.
        if (rise) begin
            since_d = PERIOD_W'(1);
        end else if (since_q != '1) begin
            since_d = since_q + PERIOD_W'(1);
        end
`endif

        if (valid_q && freq_ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = GATE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
`ifdef FREQ_METER_PERIOD_EN
                    win_per_d = '0;
`endif
                end
            end
            GATE: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    if (rise) begin
                        if (edge_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            edge_d = edge_q + CNT_W'(1);
                        end
`ifdef FREQ_METER_PERIOD_EN
                        if (edge_q != '0) begin
                            win_per_d = since_q;
                        end
`endif
                    end
                    if (gate_q == GATE_LAST) begin
                        state_d = REPORT;
                    end else begin
                        gate_d = gate_q + GATE_W'(1);
                    end
                end
            end
            REPORT: begin
                freq_d  = edge_q;
                ovf_d   = sat_q;
                valid_d = 1'b1;
                if (valid_q && !freq_ack) begin
                    overrun_d = 1'b1;
                end
                // An edge here opens the next window so none are lost.
                gate_d  = '0;
                edge_d  = CNT_W'(rise);
                sat_d   = 1'b0;
                state_d = en ? GATE : IDLE;
`ifdef FREQ_METER_PERIOD_EN
                per_d     = win_per_q;
                win_per_d = '0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clkin) begin
        if (!rst) begin
            state_q   <= IDLE;
            gate_q    <= '0;
            edge_q    <= '0;
            sat_q     <= 1'b0;
            freq_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FREQ_METER_PERIOD_EN
            since_q   <= '0;
            win_per_q <= '0;
            per_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            edge_q    <= edge_d;
            sat_q     <= sat_d;
            freq_q    <= freq_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
`ifdef FREQ_METER_PERIOD_EN
            since_q   <= since_d;
            win_per_q <= win_per_d;
            per_q     <= per_d;
`endif
        end
    end

    assign freq_out   = freq_q;
    assign freq_valid = valid_q;
    assign ovf        = ovf_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
`ifdef FREQ_METER_PERIOD_EN
    assign period_out = per_q;
`endif

endmodule : freq_meter

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (GATE_CYCLES=1000, CNT_W=8).
// Every 0->1 driven on sig_in is logged with the clock edge at which the
// meter sees it; each window's expected result is counted from that log.
module tb_freq_meter;

    localparam int G    = 1000;
    localparam int CW   = 8;
    localparam int SYNC = 2;
    localparam int W    = G + 1;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic          sig_in;
    logic [CW-1:0] freq_out;
    logic          freq_valid;
    logic          freq_ack;
    logic          ovf;
    logic          overrun;
    logic          busy;
`ifdef FREQ_METER_PERIOD_EN
    logic [31:0]   period_out;
`endif

    freq_meter #(
        .GATE_CYCLES(G),
        .CNT_W      (CW),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clkin     (clk),
        .rst       (rst),
        .en        (en),
        .sig_in    (sig_in),
        .freq_out  (freq_out),
        .freq_valid(freq_valid),
        .freq_ack  (freq_ack),
        .ovf       (ovf),
        .overrun   (overrun),
        .busy      (busy)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period_out(period_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int sig_mode = 0;       // 0 low, 1 periodic, 2 two scheduled pulses
    int per = 4;
    int ph = 0;
    int pa = -100;
    int pb = -100;
    int det_q[$];           // edge number at which each driven rise is counted
    int checks = 0;
    int errors = 0;

    // Stimulus source for sig_in; counts clock edges.
    initial begin : sig_drv
        bit nxt;
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            case (sig_mode)
                1: begin
                    ph  = (ph + 1) % per;
                    nxt = (ph < per / 2);
                end
                2: nxt = (cyc >= pa && cyc < pa + 3) || (cyc >= pb && cyc < pb + 3);
                default: nxt = 1'b0;
            endcase
            // Sampled at cyc+1, through SYNC flops, counted at cyc+SYNC+1.
            if (nxt && !sig_in) det_q.push_back(cyc + SYNC + 1);
            sig_in = nxt;
        end
    end

    // Advance to 2 time units after clock edge n.
    task automatic to_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window k of a run started at edge s: edges counted in (lo, hi].
    task automatic model_win(input int s, input int k, output int f, output int o, output int p);
        int lo, hi, n, a, b;
        lo = (k == 0) ? s : s + k * W - 1;
        hi = s + (k + 1) * W - 1;
        n = 0; a = 0; b = 0;
        foreach (det_q[i]) begin
            if (det_q[i] > lo && det_q[i] <= hi) begin
                n++;
                a = b;
                b = det_q[i];
            end
        end
        f = (n > MAXC) ? MAXC : n;
        o = (n > MAXC) ? 1 : 0;
        p = (n >= 2) ? (b - a) : 0;
    endtask

    // ack_mode: 0 ack after result, 1 no ack, 2 ack during the REPORT cycle.
    task automatic win_check(input string tag, input int s, input int k, input int pre_valid,
                             input int ack_mode, input int exp_ovr, output int f_out);
        int r, f, o, p;
        r = s + (k + 1) * W;
        to_edge(r - 1);
        chk({tag, "_valid_pre"}, 32'(freq_valid), 32'(pre_valid));
        if (ack_mode == 2) freq_ack = 1'b1;
        to_edge(r);
        freq_ack = 1'b0;
        model_win(s, k, f, o, p);
        f_out = f;
        chk({tag, "_valid"}, 32'(freq_valid), 32'd1);
        chk({tag, "_freq"}, 32'(freq_out), 32'(f));
        chk({tag, "_ovf"}, 32'(ovf), 32'(o));
        chk({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
`ifdef FREQ_METER_PERIOD_EN
        chk({tag, "_period"}, period_out, 32'(p));
`endif
        if (ack_mode == 0) begin
            freq_ack = 1'b1;
            to_edge(r + 1);
            freq_ack = 1'b0;
            chk({tag, "_valid_ack"}, 32'(freq_valid), 32'd0);
            chk({tag, "_freq_hold"}, 32'(freq_out), 32'(f));
        end
    endtask

    initial begin : main
        int s, s2, f, f6;
        rst = 1'b0; en = 1'b1; freq_ack = 1'b0;
        sig_mode = 1; per = 4;

        // Reset held with en high and sig_in toggling.
        to_edge(3);
        chk("rst_freq", 32'(freq_out), 32'd0);
        chk("rst_valid", 32'(freq_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        to_edge(4);
        chk("rel_busy", 32'(busy), 32'd1);
        en = 1'b0; sig_mode = 0;
        to_edge(6);
        chk("abort0_busy", 32'(busy), 32'd0);
        to_edge(20);
        chk("abort0_valid", 32'(freq_valid), 32'd0);

        // Continuous windows: basic, random periods, saturation, overrun.
        per = 100; ph = per - 1; sig_mode = 1;
        en = 1'b1;
        s = cyc + 1;
        win_check("w0", s, 0, 0, 0, 0, f);
        per = 2 * $urandom_range(10, 150);
        win_check("w1", s, 1, 0, 0, 0, f);
        per = 2 * $urandom_range(3, 40);
        win_check("w2", s, 2, 0, 0, 0, f);
        per = 2;
        win_check("sat", s, 3, 0, 0, 0, f);
        per = 100;
        win_check("w4", s, 4, 0, 1, 0, f);
        per = 2 * $urandom_range(10, 150);
        win_check("ackrep", s, 5, 1, 2, 0, f);
        per = 2 * $urandom_range(10, 150);
        win_check("ovr", s, 6, 1, 1, 1, f6);
        freq_ack = 1'b1;
        to_edge(s + 7 * W + 1);
        freq_ack = 1'b0;
        chk("ovr_valid_ack", 32'(freq_valid), 32'd0);

        // Abort at gate cycle 500 of the next window.
        to_edge(s + 7 * W + 500);
        en = 1'b0; sig_mode = 0;
        to_edge(s + 7 * W + 502);
        chk("abort_busy", 32'(busy), 32'd0);
        to_edge(s + 7 * W + 600);
        freq_ack = 1'b1;
        to_edge(s + 7 * W + 601);
        freq_ack = 1'b0;
        chk("idle_ack_valid", 32'(freq_valid), 32'd0);
        to_edge(s + 8 * W + 5);
        chk("abort_valid", 32'(freq_valid), 32'd0);
        chk("abort_freq", 32'(freq_out), 32'(f6));
        chk("abort_overrun", 32'(overrun), 32'd1);

        // Single edges: one in the final gate cycle, one in a REPORT cycle.
        s2 = cyc + 1;
        pa = s2 + G - (SYNC + 1);
        pb = s2 + 2 * W - (SYNC + 1);
        sig_mode = 2;
        en = 1'b1;
        win_check("bnd_last", s2, 0, 0, 0, 1, f);
        win_check("bnd_rep_old", s2, 1, 0, 0, 1, f);
        win_check("bnd_rep_new", s2, 2, 0, 0, 1, f);
        en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_freq_meter

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a slow external or derived square wave, such as the output of the 10 Hz divider or a sensor pulse line.
- Counts rising edges of `sig_in` over a fixed gate window of `clkin` cycles and reports the count (Hz when the gate is 1 s) through a valid/ack handshake.
- Acts as the receiving end of the divided-clock path: it lets the board self-check its dividers and drives the display units.

Parameters:
- `GATE_CYCLES`, default 50_000_000: gate window length in `clkin` cycles (1 s at 50 MHz); must be ≥ 4.
- `CNT_W`, default 16: width of edge counter and result.
- `SYNC_STAGES`, default 2: flip-flop stages in the `sig_in` synchronizer; must be ≥ 2.

Ports:
- `clkin` input 1: system clock, all logic on its rising edge.
- `rst` input 1: synchronous, active-low reset (0 = reset), sampled on rising `clkin`.
- `en` input 1: 1 = run continuous gate windows; 0 = idle.
- `sig_in` input 1: asynchronous signal under measurement.
- `freq_out` output CNT_W: edge count of the last completed window.
- `freq_valid` output 1: `freq_out` holds an unacknowledged result.
- `freq_ack` input 1: consumer accepts the result; effective only while `freq_valid` = 1.
- `ovf` output 1: edge count saturated in the reported window.
- `overrun` output 1: sticky; a new result replaced an unacknowledged one.
- `busy` output 1: a gate window is in progress.

Behaviour:
- **Reset** (`rst` = 0 at a clock edge): state IDLE; gate counter, edge counter, synchronizer and edge-detect registers all cleared. Outputs: `freq_out` = 0, `freq_valid` = 0, `ovf` = 0, `overrun` = 0, `busy` = 0.
- **Synchronizer:** `sig_in` passes through SYNC_STAGES flops, then a one-flop rising-edge detector. `rise` pulses one cycle, SYNC_STAGES+1 cycles after a clean 0→1 on `sig_in`. Glitches shorter than one `clkin` period are not guaranteed counted.
- **FSM states:** IDLE, GATE, REPORT.
- **IDLE:**
  - `busy` = 0; edge-detect history keeps updating so a level already high at start is not counted.
  - If `en` = 1: clear gate and edge counters, go to GATE next cycle.
- **GATE:**
  - `busy` = 1; gate counter increments each cycle from 0 to GATE_CYCLES-1.
  - Each `rise` increments the edge counter; the counter saturates at 2^CNT_W-1 and sets an internal `sat` flag.
  - A `rise` in the final gate cycle (counter = GATE_CYCLES-1) is counted in this window.
  - After the final cycle, go to REPORT.
  - If `en` = 0 during GATE: abort to IDLE next cycle; no result; `freq_*` unchanged.
- **REPORT** (one cycle):
  - Load `freq_out` ← edge count and `ovf` ← `sat`; set `freq_valid` = 1.
  - If `freq_valid` was already 1 and no ack arrives this cycle, set `overrun` = 1.
  - Clear counters and `sat`. Go to GATE if `en` = 1, else IDLE.
  - A `rise` in the REPORT cycle is counted as the first edge of the next window, so no edges are lost between back-to-back windows.
  - Window period = GATE_CYCLES+1 cycles.
- **Handshake:**
  - `freq_valid` falls the cycle after `freq_ack` = 1 is sampled with `freq_valid` = 1; `freq_out` and `ovf` hold their values.
  - Ack and REPORT in the same cycle: the new result loads, `freq_valid` stays 1, and no overrun is raised.
  - Ack while `freq_valid` = 0 is ignored.
- **`overrun`:** cleared only by reset.
- **Latency:** `freq_valid` rises 1 cycle after the last gate cycle.

Optional Feature:
- Macro: `FREQ_METER_PERIOD_EN`.
- **Defined:**
  - Adds output `period_out` [31:0]: `clkin` cycles between the last two `rise` pulses of the reported window, latched in REPORT.
  - `period_out` = 0 if the window saw fewer than 2 edges; saturates at 2^32-1.
  - Reset value 0.
- **Undefined:** no `period_out` port and no period logic; all other behaviour identical.

Decomposition:
- Package `freq_meter_pkg`: FSM state enum (IDLE, GATE, REPORT), default constants for GATE_CYCLES/CNT_W/SYNC_STAGES, and `PERIOD_W` = 32.
- One sub-module, `edge_sync`: parameterised SYNC_STAGES synchronizer plus rising-edge detector; ports `clkin`, `rst`, `d`, `rise`.

Test Plan (sim with GATE_CYCLES = 1000, CNT_W = 8 unless noted):
- **Reset:** hold `rst` = 0 for 3 cycles with `en` = 1 and `sig_in` toggling → all outputs 0 and `busy` = 0. Release → `busy` = 1 the next cycle.
- **Basic window:** `sig_in` period 100 cycles (50 high), `en` = 1, ack each result → `freq_out` = 10, `ovf` = 0, `freq_valid` pulses every 1001 cycles.
- **Saturation:** `sig_in` period 2 cycles → 500 edges exceed 255 → `freq_out` = 255, `ovf` = 1.
- **Overrun:** no ack across two windows → second result loads and `overrun` = 1. Ack in the same cycle as REPORT → `overrun` stays 0 and `freq_valid` stays 1.
- **Boundaries and abort:**
  - Single edge timed to land `rise` in the final gate cycle → counted in that window.
  - Edge landing in the REPORT cycle → counted in the next window.
  - `en` dropped at gate cycle 500 → no `freq_valid`, `freq_out` unchanged.
- **Period feature:** with `FREQ_METER_PERIOD_EN` defined and `sig_in` period 100 → `period_out` = 100; with a single edge per window → `period_out` = 0.
